// File: rtl/mlp_eval_sequencer_if.sv
// ---------------------------------------------------------------------------
// mlp_eval_sequencer_if
//
// Purpose: bundles the signals between the evaluation sequencer, the MLP
// and the label memory.
//
// Signals:
//   mlp_rst       sequencer -> MLP        hold the MLP in reset
//   mlp_start     sequencer -> MLP        one-cycle start pulse
//   mlp_test_num  sequencer -> MLP/label  sample index (also label_mem address)
//   label_read    sequencer -> label_mem  read enable, high in the compare cycle
//   mlp_out       MLP -> sequencer        classification result
//   mlp_done      MLP -> sequencer        completion flag
//   label         label_mem -> sequencer  expected label, combinational from
//                                         mlp_test_num
//
// Handshake: mlp_start acts as a one-cycle "valid" for mlp_test_num. The MLP
// answers with mlp_done (its "ready/valid" for mlp_out), which it keeps high,
// with mlp_out stable, until the next mlp_rst. mlp_done is only honoured
// while the sequencer is waiting for it, so a level left over from the
// previous test is ignored; the MLP reset between tests clears it anyway.
// ---------------------------------------------------------------------------
interface mlp_eval_sequencer_if #(
    parameter int IDX_W = 10,
    parameter int LBL_W = 4
);
    logic             mlp_rst;
    logic             mlp_start;
    logic [IDX_W-1:0] mlp_test_num;
    logic             label_read;
    logic [LBL_W-1:0] mlp_out;
    logic             mlp_done;
    logic [LBL_W-1:0] label;

    // Sequencer side
    modport master (
        output mlp_rst,
        output mlp_start,
        output mlp_test_num,
        output label_read,
        input  mlp_out,
        input  mlp_done,
        input  label
    );

    // MLP / label memory side
    modport slave (
        input  mlp_rst,
        input  mlp_start,
        input  mlp_test_num,
        input  label_read,
        output mlp_out,
        output mlp_done,
        output label
    );
endinterface

// File: rtl/mlp_eval_sequencer.sv
// ---------------------------------------------------------------------------
// mlp_eval_sequencer
//
// Purpose: synthesizable driver that evaluates the MLP over NUM_TESTS
// consecutive samples. Per test it resets the MLP, pulses start with the
// sample index, waits for done (or a timeout), compares the result with the
// label memory and updates the accuracy counters.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   go            start a run (only looked at in IDLE)
//   base_idx      first sample index of the run, latched on go
//   mlp           interface to MLP and label memory (master side)
//   busy          run in progress
//   finished      run complete, held until next go or rst
//   correct_cnt   tests where mlp_out matched the label
//   total_cnt     tests completed, timeouts included
//   timeout_cnt   tests ended by timeout
//   dbg_state     current FSM state encoding
// ---------------------------------------------------------------------------
module mlp_eval_sequencer #(
    parameter int NUM_TESTS   = 100,
    parameter int NUM_SAMPLES = 750,
    parameter int IDX_W       = 10,
    parameter int LBL_W       = 4,
    parameter int TIMEOUT     = 255,
    parameter int CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        go,
    input  logic [IDX_W-1:0]            base_idx,
    mlp_eval_sequencer_if.master        mlp,
    output logic                        busy,
    output logic                        finished,
    output logic [CNT_W-1:0]            correct_cnt,
    output logic [CNT_W-1:0]            total_cnt,
    output logic [CNT_W-1:0]            timeout_cnt,
    output logic [2:0]                  dbg_state
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MRST  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_CHECK = 3'd4,
        S_NEXT  = 3'd5,
        S_FIN   = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    test_num_q, test_num_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                timeout_q, timeout_d;
    logic                finished_q, finished_d;
    logic [CNT_W-1:0]    correct_q, correct_d;
    logic [CNT_W-1:0]    total_q, total_d;
    logic [CNT_W-1:0]    to_cnt_q, to_cnt_d;

    logic [WAIT_W-1:0]   wait_inc;
    logic                timeout_hit;
    logic                run_done;
    logic [LBL_W-1:0]    out_s;
    logic [LBL_W-1:0]    lbl_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // The wait counter holds the number of completed WAIT cycles; the cycle
    // in which it would reach TIMEOUT is the last one spent waiting.
    assign wait_inc    = wait_q + 1'b1;
    assign timeout_hit = (wait_inc == WAIT_W'(TIMEOUT));
    assign run_done    = (total_q == CNT_W'(NUM_TESTS));
    assign out_s       = mlp.mlp_out;
    assign lbl_s       = mlp.label;

    // ---------------- state register (all flops) ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            test_num_q <= '0;
            wait_q     <= '0;
            timeout_q  <= 1'b0;
            finished_q <= 1'b0;
            correct_q  <= '0;
            total_q    <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            test_num_q <= test_num_d;
            wait_q     <= wait_d;
            timeout_q  <= timeout_d;
            finished_q <= finished_d;
            correct_q  <= correct_d;
            total_q    <= total_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go) state_d = S_MRST;
            S_MRST:  state_d = S_START;
            S_START: state_d = S_WAIT;
            // done has priority over the timeout; both leave to CHECK
            S_WAIT:  if (mlp.mlp_done || timeout_hit) state_d = S_CHECK;
            S_CHECK: state_d = S_NEXT;
            S_NEXT:  state_d = run_done ? S_FIN : S_MRST;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        test_num_d = test_num_q;
        wait_d     = wait_q;
        timeout_d  = timeout_q;
        finished_d = finished_q;
        correct_d  = correct_q;
        total_d    = total_q;
        to_cnt_d   = to_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    test_num_d = base_idx;
                    correct_d  = '0;
                    total_d    = '0;
                    to_cnt_d   = '0;
                    finished_d = 1'b0;
                end
            end
            S_START: begin
                wait_d = '0;
            end
            S_WAIT: begin
                wait_d    = wait_inc;
                // Only the value from the final WAIT cycle reaches CHECK.
                timeout_d = timeout_hit & ~mlp.mlp_done;
            end
            S_CHECK: begin
                total_d = sat_inc(total_q);
                if (timeout_q) begin
                    to_cnt_d = sat_inc(to_cnt_q);
                end else if (out_s == lbl_s) begin
                    correct_d = sat_inc(correct_q);
                end
            end
            S_NEXT: begin
                if (run_done) begin
                    finished_d = 1'b1;
                end else if (test_num_q == IDX_W'(NUM_SAMPLES - 1)) begin
                    test_num_d = '0;
                end else begin
                    test_num_d = test_num_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        mlp.mlp_rst    = 1'b0;
        mlp.mlp_start  = 1'b0;
        mlp.label_read = 1'b0;
        busy           = 1'b1;
        case (state_q)
            S_IDLE:  begin mlp.mlp_rst = 1'b1; busy = 1'b0; end
            S_MRST:  mlp.mlp_rst = 1'b1;
            S_START: mlp.mlp_start = 1'b1;
            S_CHECK: mlp.label_read = 1'b1;
            S_FIN:   begin mlp.mlp_rst = 1'b1; busy = 1'b0; end
            default: ;
        endcase
    end

    assign mlp.mlp_test_num = test_num_q;
    assign finished         = finished_q;
    assign correct_cnt      = correct_q;
    assign total_cnt        = total_q;
    assign timeout_cnt      = to_cnt_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_mlp_eval_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mlp_eval_sequencer
//
// Bench for mlp_eval_sequencer. A behavioural MLP answers each start pulse
// after a per-sample latency taken from lat_plan (very large = never), and
// returns a wrong class for samples flagged in wrong_plan. Expected counter
// values, run length and the index sequence are worked out per run from
// those plans with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_mlp_eval_sequencer;

    localparam int NT    = 10;
    localparam int NS    = 750;
    localparam int IW    = 10;
    localparam int LW    = 4;
    localparam int TO    = 255;
    localparam int CW    = 16;
    localparam int NEVER = 100000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          go = 1'b0;
    logic [IW-1:0] base_idx = '0;
    logic          busy, finished;
    logic [CW-1:0] correct_cnt, total_cnt, timeout_cnt;
    logic [2:0]    dbg_state;

    mlp_eval_sequencer_if #(.IDX_W(IW), .LBL_W(LW)) bus ();

    mlp_eval_sequencer #(
        .NUM_TESTS(NT), .NUM_SAMPLES(NS), .IDX_W(IW),
        .LBL_W(LW), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .base_idx    (base_idx),
        .mlp         (bus.master),
        .busy        (busy),
        .finished    (finished),
        .correct_cnt (correct_cnt),
        .total_cnt   (total_cnt),
        .timeout_cnt (timeout_cnt),
        .dbg_state   (dbg_state)
    );

    // ---------------- MLP and label memory model ----------------
    int            lat_plan   [NS];
    bit            wrong_plan [NS];
    logic [LW-1:0] lbl_mem    [NS];
    int            lat_cur = 0;
    int            run_cnt = 0;
    bit            running = 1'b0;

    always @(posedge clk) begin
        if (bus.mlp_rst) begin
            running <= 1'b0;
            run_cnt <= 0;
        end else if (bus.mlp_start) begin
            running <= 1'b1;
            run_cnt <= 1;
            lat_cur <= lat_plan[bus.mlp_test_num];
        end else if (running && run_cnt < NEVER) begin
            run_cnt <= run_cnt + 1;
        end
    end

    // done rises L cycles after the start pulse and stays until mlp_rst
    assign bus.mlp_done = running && (run_cnt >= lat_cur);
    assign bus.label    = lbl_mem[bus.mlp_test_num];
    assign bus.mlp_out  = wrong_plan[bus.mlp_test_num] ? bus.label + LW'(1) : bus.label;

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [IW-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // mode 0 random, 1 all correct L=160, 2 odd indices wrong,
    // 3 never done, 4 done exactly at TIMEOUT, 5 latency 254/255/256
    task automatic plan_fill(input int mode);
        for (int i = 0; i < NS; i++) begin
            case (mode)
                1: begin lat_plan[i] = 160; wrong_plan[i] = 1'b0; end
                2: begin lat_plan[i] = $urandom_range(1, 40); wrong_plan[i] = (i % 2) == 1; end
                3: begin lat_plan[i] = NEVER; wrong_plan[i] = 1'b0; end
                4: begin lat_plan[i] = TO; wrong_plan[i] = 1'b0; end
                5: begin lat_plan[i] = TO - 1 + (i % 3); wrong_plan[i] = 1'b0; end
                default: begin
                    lat_plan[i]   = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(1, 300);
                    wrong_plan[i] = $urandom_range(0, 1) == 1;
                end
            endcase
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_mlp_rst"}, bus.mlp_rst, 1);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_finished"}, finished, 0);
        check_eq({tag, "_counters"}, {correct_cnt, total_cnt} | timeout_cnt, 0);
        check_eq({tag, "_state"}, dbg_state, 0);
    endtask

    // One run from base b. glitch>0: pulse go at that cycle of the run.
    // rst_at>0: reset in the first WAIT cycle of that test and stop.
    task automatic do_run(input int b, input int glitch, input int rst_at);
        int exp_cycles, exp_correct, exp_to, cycles, starts, limit;
        logic [IW-1:0] last_idx;
        bit aborted;
        exp_q.delete();
        exp_cycles = 0; exp_correct = 0; exp_to = 0;
        for (int t = 0; t < NT; t++) begin
            int idx, lat;
            bit is_to;
            idx   = (b + t) % NS;
            lat   = lat_plan[idx];
            is_to = lat > TO;
            exp_q.push_back(IW'(idx));
            exp_cycles += (is_to ? TO : lat) + 4;
            if (is_to) exp_to++;
            else if (!wrong_plan[idx]) exp_correct++;
        end
        limit = exp_cycles + 50;

        @(negedge clk); go = 1'b1; base_idx = IW'(b);
        @(negedge clk); go = 1'b0;
        cycles = 0; starts = 0; aborted = 1'b0; last_idx = '0;
        while (!finished && cycles < limit && !aborted) begin
            if (bus.mlp_start) begin
                starts++;
                last_idx = bus.mlp_test_num;
                if (exp_q.size() > 0) check_eq("test_num", bus.mlp_test_num, exp_q.pop_front());
                else check_eq("extra_start", starts, NT);
            end
            if (bus.label_read) check_eq("test_num_stable", bus.mlp_test_num, last_idx);
            if (glitch > 0 && cycles == glitch) begin
                go = 1'b1;
                base_idx = IW'($urandom_range(0, NS - 1));
            end else begin
                go = 1'b0;
            end
            if (rst_at > 0 && starts == rst_at && dbg_state == 3'd3) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_reset_state("mid_rst");
                aborted = 1'b1;
            end else begin
                @(negedge clk);
                cycles++;
            end
        end
        go = 1'b0;
        if (!aborted) begin
            check_eq("finished_seen", finished, 1);
            check_eq("run_cycles", cycles, exp_cycles);
            check_eq("correct_cnt", correct_cnt, exp_correct);
            check_eq("total_cnt", total_cnt, NT);
            check_eq("timeout_cnt", timeout_cnt, exp_to);
            check_eq("fin_busy", busy, 0);
            check_eq("fin_mlp_rst", bus.mlp_rst, 1);
            @(negedge clk);
            check_eq("finished_held", finished, 1);
            check_eq("idle_state", dbg_state, 0);
            check_eq("correct_held", correct_cnt, exp_correct);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < NS; i++) lbl_mem[i] = LW'($urandom_range(0, 9));
        plan_fill(0);

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        check_eq("reset_start", bus.mlp_start, 0);
        check_eq("reset_test_num", bus.mlp_test_num, 0);
        check_eq("reset_label_read", bus.label_read, 0);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("idle");

        plan_fill(1); do_run(0, 0, 0);
        plan_fill(2); do_run(0, 0, 0);
        plan_fill(0); do_run(748, 0, 0);
        plan_fill(3); do_run(20, 0, 0);
        plan_fill(4); do_run(100, 300, 0);
        plan_fill(5); do_run(740, 0, 0);
        plan_fill(0); do_run(0, 0, 5);
        do_run(0, 0, 0);
        for (int r = 0; r < 4; r++) begin
            plan_fill(0);
            do_run($urandom_range(0, NS - 1), $urandom_range(1, 40), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
